// File: rtl/opb_register_bank_ppc2simulink.sv
// OPB slave register bank bridging PowerPC software to user logic.
// Build option: define OPB_REGBANK_SHADOW_COMMIT_EN to give every register a
// shadow copy that bus writes target, with a COMMIT word that copies selected
// shadows to the user-facing registers. Without it, bus writes land directly
// in the user-facing registers.
module opb_register_bank_ppc2simulink #(
  parameter logic [31:0] C_BASEADDR  = 32'h01002000,
  parameter logic [31:0] C_HIGHADDR  = 32'h010020FF,
  parameter int          C_NUM_REGS  = 8,
  parameter int          C_REG_WIDTH = 32,
  parameter logic [31:0] C_RESET_VAL = 32'h0
) (
  input  logic                              OPB_Clk,
  input  logic                              OPB_Rst_n,
  input  logic [0:31]                       OPB_ABus,
  input  logic [0:3]                        OPB_BE,
  input  logic [0:31]                       OPB_DBus,
  input  logic                              OPB_RNW,
  input  logic                              OPB_select,
  input  logic                              OPB_seqAddr,
  output logic [0:31]                       Sl_DBus,
  output logic                              Sl_xferAck,
  output logic                              Sl_errAck,
  output logic                              Sl_retry,
  output logic                              Sl_toutSup,
  output logic [C_NUM_REGS*C_REG_WIDTH-1:0] user_data_out,
  output logic [C_NUM_REGS-1:0]             user_update
);

  typedef logic [C_REG_WIDTH-1:0] reg_t;
  typedef enum logic [1:0] {S_IDLE, S_ACK, S_WAIT} state_t;

  localparam reg_t RST_VAL = C_RESET_VAL[C_REG_WIDTH-1:0];

  // Merge write data into a register honouring byte enables (be[3] = MSB byte).
  function automatic reg_t merge_bytes(reg_t old, logic [31:0] wd, logic [3:0] be);
    logic [31:0] m;
    logic [31:0] r;
    m = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
    r = (32'(old) & ~m) | (wd & m);
    return r[C_REG_WIDTH-1:0];
  endfunction

  // OPB numbers bit 0 as MSB; plain assignment keeps numeric value intact.
  logic [31:0] abus;
  logic [31:0] wdbus;
  logic [3:0]  bebus;
  logic [31:0] offset;
  logic [31:0] idx;
  logic        hit;
  logic        unused_bits;

  assign abus        = OPB_ABus;
  assign wdbus       = OPB_DBus;
  assign bebus       = OPB_BE;
  assign offset      = abus - C_BASEADDR;
  assign idx         = {2'b00, offset[31:2]};
  assign hit         = OPB_select && (abus >= C_BASEADDR) && (abus <= C_HIGHADDR);
  assign unused_bits = ^{OPB_seqAddr, offset[1:0]};

  state_t      state_q;
  logic        ack_q;
  logic [31:0] rdata_q;
  logic [31:0] idx_q;
  logic        rnw_q;
  logic [3:0]  be_q;
  logic [31:0] wdata_q;

  reg_t                  active_q [C_NUM_REGS];
  reg_t                  active_d [C_NUM_REGS];
  reg_t                  rd_src   [C_NUM_REGS];
  logic [C_NUM_REGS-1:0] upd_q;
  logic [C_NUM_REGS-1:0] upd_d;
  logic [31:0]           rd_word;
  logic                  wr_ack;

`ifdef OPB_REGBANK_SHADOW_COMMIT_EN
  reg_t shadow_q [C_NUM_REGS];
  reg_t shadow_d [C_NUM_REGS];
`endif

  // Select the register image software reads back.
  always_comb begin
    for (int i = 0; i < C_NUM_REGS; i++) begin
`ifdef OPB_REGBANK_SHADOW_COMMIT_EN
      rd_src[i] = shadow_q[i];
`else
      rd_src[i] = active_q[i];
`endif
    end
  end

  // Read mux; COMMIT and unmapped offsets fall through to zero.
  always_comb begin
    rd_word = '0;
    for (int i = 0; i < C_NUM_REGS; i++) begin
      if (idx == 32'(i)) rd_word = 32'(rd_src[i]);
    end
  end

  // Bus handshake FSM: capture the transfer on a hit, ack once, wait for select to drop.
  always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
    if (!OPB_Rst_n) begin
      state_q <= S_IDLE;
      ack_q   <= 1'b0;
      rdata_q <= '0;
      idx_q   <= '0;
      rnw_q   <= 1'b1;
      be_q    <= '0;
      wdata_q <= '0;
    end else begin
      ack_q   <= 1'b0;
      rdata_q <= '0;
      case (state_q)
        S_IDLE: begin
          if (hit) begin
            state_q <= S_ACK;
            ack_q   <= 1'b1;
            rdata_q <= OPB_RNW ? rd_word : 32'h0;
            idx_q   <= idx;
            rnw_q   <= OPB_RNW;
            be_q    <= bebus;
            wdata_q <= wdbus;
          end
        end
        S_ACK:   state_q <= S_WAIT;
        S_WAIT:  if (!OPB_select) state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign wr_ack = (state_q == S_ACK) && !rnw_q;

  // Register write / commit next-state; update pulses last exactly one cycle.
  always_comb begin
    active_d = active_q;
    upd_d    = '0;
`ifdef OPB_REGBANK_SHADOW_COMMIT_EN
    shadow_d = shadow_q;
    for (int i = 0; i < C_NUM_REGS; i++) begin
      if (wr_ack && idx_q == 32'(i)) shadow_d[i] = merge_bytes(shadow_q[i], wdata_q, be_q);
      if (wr_ack && idx_q == 32'(C_NUM_REGS) && wdata_q[i]) begin
        active_d[i] = shadow_q[i];
        upd_d[i]    = 1'b1;
      end
    end
`else
    for (int i = 0; i < C_NUM_REGS; i++) begin
      if (wr_ack && idx_q == 32'(i)) begin
        active_d[i] = merge_bytes(active_q[i], wdata_q, be_q);
        upd_d[i]    = 1'b1;
      end
    end
`endif
  end

  // Register storage and update-pulse flops.
  always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
    if (!OPB_Rst_n) begin
      for (int i = 0; i < C_NUM_REGS; i++) begin
        active_q[i] <= RST_VAL;
`ifdef OPB_REGBANK_SHADOW_COMMIT_EN
        shadow_q[i] <= RST_VAL;
`endif
      end
      upd_q <= '0;
    end else begin
      active_q <= active_d;
`ifdef OPB_REGBANK_SHADOW_COMMIT_EN
      shadow_q <= shadow_d;
`endif
      upd_q <= upd_d;
    end
  end

  // Flatten the user-facing registers onto the output bus.
  always_comb begin
    user_data_out = '0;
    for (int i = 0; i < C_NUM_REGS; i++) begin
      user_data_out[i*C_REG_WIDTH +: C_REG_WIDTH] = active_q[i];
    end
  end

  assign user_update = upd_q;
  assign Sl_DBus     = rdata_q;
  assign Sl_xferAck  = ack_q;
  assign Sl_errAck   = 1'b0;
  assign Sl_retry    = 1'b0;
  assign Sl_toutSup  = 1'b0;

endmodule
